riscv_mem_arbiter: RTL and testbench

//  Shares one single-ported instruction/data memory between the IF stage (fetch) and the MEM stage
//  (load/store). Sits between the pipeline and the memory; one transaction in flight at a time.

---
 rtl/riscv_cpu_pkg.sv | 21 ++
 rtl/riscv_mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_cpu_pkg.sv
// Shared CPU definitions: bus widths and the memory arbiter's state/owner encodings.
package riscv_cpu_pkg;

    localparam int unsigned DATA_WIDTH   = 32;
    localparam int unsigned MEM_BE_WIDTH = DATA_WIDTH / 8;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_HOLD     = 2'd1,
        ARB_WAIT_RSP = 2'd2
    } arb_state_e;

    // Which requester currently owns (or is about to own) the memory port
    typedef enum logic [1:0] {
        ARB_OWNER_NONE = 2'd0,
        ARB_OWNER_IF   = 2'd1,
        ARB_OWNER_DM   = 2'd2
    } arb_owner_e;

endpackage

// File: rtl/riscv_mem_arbiter.sv
// Shares a single-ported memory between instruction fetch and the load/store stage.
// One transaction in flight at a time; the data side has priority, but a streak counter
// limits how many data grants may overtake a pending fetch.
module riscv_mem_arbiter
    import riscv_cpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = riscv_cpu_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    if_req,
    input  logic [ADDR_W-1:0]       if_addr,
    output logic                    if_gnt,
    output logic                    if_rvalid,
    output logic [DATA_WIDTH-1:0]   if_rdata,

    input  logic                    dm_req,
    input  logic [ADDR_W-1:0]       dm_addr,
    input  logic                    dm_we,
    input  logic [MEM_BE_WIDTH-1:0] dm_be,
    input  logic [DATA_WIDTH-1:0]   dm_wdata,
    output logic                    dm_gnt,
    output logic                    dm_rvalid,
    output logic [DATA_WIDTH-1:0]   dm_rdata,

    output logic                    mem_req,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_we,
    output logic [MEM_BE_WIDTH-1:0] mem_be,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int unsigned STREAK_W = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    arb_state_e          state_q, state_d;
    arb_owner_e          owner_q, owner_d;
    arb_owner_e          winner;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                grant;

    // Priority select: fresh arbitration only in IDLE, frozen to the owner in HOLD
    always_comb begin
        winner = ARB_OWNER_NONE;
        case (state_q)
            ARB_IDLE: begin
                if (dm_req && (!if_req || (streak_q < STREAK_MAX))) begin
                    winner = ARB_OWNER_DM;
                end else if (if_req) begin
                    winner = ARB_OWNER_IF;
                end
            end
            ARB_HOLD: winner = owner_q;
            default:  winner = ARB_OWNER_NONE;
        endcase
    end

    assign grant = mem_gnt && (winner != ARB_OWNER_NONE);

    // State, owner and streak registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            owner_q  <= ARB_OWNER_NONE;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            streak_q <= streak_d;
        end
    end

    // Next-state and owner tracking
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            ARB_IDLE: begin
                if (winner != ARB_OWNER_NONE) begin
                    owner_d = winner;
                    state_d = mem_gnt ? ARB_WAIT_RSP : ARB_HOLD;
                end
            end
            ARB_HOLD: begin
                if (mem_gnt) begin
                    state_d = ARB_WAIT_RSP;
                end
            end
            ARB_WAIT_RSP: begin
                if (mem_rvalid) begin
                    owner_d = ARB_OWNER_NONE;
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                owner_d = ARB_OWNER_NONE;
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Streak of data grants taken while a fetch was waiting; cleared by a fetch grant
    // or by any idle cycle with no fetch pending
    always_comb begin
        streak_d = streak_q;
        if (grant && (winner == ARB_OWNER_IF)) begin
            streak_d = '0;
        end else if (grant && (winner == ARB_OWNER_DM) && if_req) begin
            if (streak_q < STREAK_MAX) begin
                streak_d = streak_q + 1'b1;
            end
        end else if ((state_q == ARB_IDLE) && !if_req) begin
            streak_d = '0;
        end
    end

    // Output muxes: request path from the winner, response path to the owner
    always_comb begin
        mem_req   = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_wdata = '0;
        if_gnt    = 1'b0;
        dm_gnt    = 1'b0;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        dm_rvalid = 1'b0;
        dm_rdata  = '0;

        case (winner)
            ARB_OWNER_IF: begin
                mem_req  = 1'b1;
                mem_addr = if_addr;
                if_gnt   = mem_gnt;
            end
            ARB_OWNER_DM: begin
                mem_req   = 1'b1;
                mem_addr  = dm_addr;
                mem_we    = dm_we;
                mem_be    = dm_be;
                mem_wdata = dm_wdata;
                dm_gnt    = mem_gnt;
            end
            default: ;
        endcase

        if ((state_q == ARB_WAIT_RSP) && mem_rvalid) begin
            case (owner_q)
                ARB_OWNER_IF: begin
                    if_rvalid = 1'b1;
                    if_rdata  = mem_rdata;
                end
                ARB_OWNER_DM: begin
                    dm_rvalid = 1'b1;
                    dm_rdata  = mem_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Scoreboard bench for riscv_mem_arbiter: requester agents, a behavioural memory and a monitor
// that pops predicted grants/responses as the DUT produces them.
module tb_riscv_mem_arbiter;
    import riscv_cpu_pkg::*;

    typedef struct packed {
        logic        is_dm;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } gnt_t;

    typedef struct packed {
        logic        is_dm;
        logic [31:0] data;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    logic        rsp_v, stale_v, rsp_en;
    logic [31:0] rsp_d, stale_d;
    assign mem_rvalid = rsp_v | stale_v;
    assign mem_rdata  = rsp_d | stale_d;

    logic [31:0] mem_arr [256];
    logic [31:0] ref_mem [256];

    gnt_t        exp_gnt [$];
    rsp_t        exp_rsp [$];
    logic [31:0] if_q [$];
    gnt_t        dm_q [$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    riscv_mem_arbiter #(
        .DATA_WIDTH      (32),
        .ADDR_W          (32),
        .MAX_DATA_STREAK (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .dm_req     (dm_req),
        .dm_addr    (dm_addr),
        .dm_we      (dm_we),
        .dm_be      (dm_be),
        .dm_wdata   (dm_wdata),
        .dm_gnt     (dm_gnt),
        .dm_rvalid  (dm_rvalid),
        .dm_rdata   (dm_rdata),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected grant/response for a fetch, predicted from the reference memory image
    function automatic void exp_if(input logic [31:0] a, input bit with_rsp);
        logic [7:0] idx;
        idx = a[9:2];
        exp_gnt.push_back('{is_dm: 1'b0, addr: a, we: 1'b0, be: 4'h0, wdata: 32'h0});
        if (with_rsp) exp_rsp.push_back('{is_dm: 1'b0, data: ref_mem[idx]});
    endfunction

    function automatic void exp_dm(input logic [31:0] a, input logic we, input logic [3:0] be,
                                   input logic [31:0] wd);
        logic [7:0] idx;
        idx = a[9:2];
        exp_gnt.push_back('{is_dm: 1'b1, addr: a, we: we, be: be, wdata: wd});
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
            end
            exp_rsp.push_back('{is_dm: 1'b1, data: 32'h0});
        end else begin
            exp_rsp.push_back('{is_dm: 1'b1, data: ref_mem[idx]});
        end
    endfunction

    function automatic gnt_t dm_op(input logic [31:0] a, input logic we, input logic [3:0] be,
                                   input logic [31:0] wd);
        return '{is_dm: 1'b1, addr: a, we: we, be: be, wdata: wd};
    endfunction

    task automatic run_if();
        logic [31:0] a;
        bit got;
        while (if_q.size() > 0) begin
            a = if_q.pop_front();
            if_req  = 1'b1;
            if_addr = a;
            got = 1'b0;
            for (int c = 0; c < 200 && !got; c++) begin
                @(negedge clk);
                got = if_gnt;
            end
            chk("if_gnt_wait", 64'(got), 64'd1);
            @(posedge clk); #1;
        end
        if_req  = 1'b0;
        if_addr = '0;
    endtask

    task automatic run_dm();
        gnt_t r;
        bit got;
        while (dm_q.size() > 0) begin
            r = dm_q.pop_front();
            dm_req   = 1'b1;
            dm_addr  = r.addr;
            dm_we    = r.we;
            dm_be    = r.be;
            dm_wdata = r.wdata;
            got = 1'b0;
            for (int c = 0; c < 200 && !got; c++) begin
                @(negedge clk);
                got = dm_gnt;
            end
            chk("dm_gnt_wait", 64'(got), 64'd1);
            @(posedge clk); #1;
        end
        dm_req   = 1'b0;
        dm_addr  = '0;
        dm_we    = 1'b0;
        dm_be    = '0;
        dm_wdata = '0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ctl"}, 64'({mem_req, mem_we, mem_be, if_gnt, if_rvalid, dm_gnt, dm_rvalid}), 64'd0);
        chk({tag, "_mbus"}, {mem_addr, mem_wdata}, 64'd0);
        chk({tag, "_rdata"}, {if_rdata, dm_rdata}, 64'd0);
        chk({tag, "_state"}, 64'(dut.state_q), 64'(ARB_IDLE));
    endtask

    // Behavioural memory: accepts on mem_req&&mem_gnt, answers two cycles after the grant cycle
    initial begin : responder
        logic [7:0]  idx;
        logic [31:0] rd;
        rsp_v = 1'b0;
        rsp_d = '0;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_en && mem_req && mem_gnt) begin
                idx = mem_addr[9:2];
                rd  = '0;
                if (mem_we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (mem_be[b]) mem_arr[idx][8*b +: 8] = mem_wdata[8*b +: 8];
                    end
                end else begin
                    rd = mem_arr[idx];
                end
                repeat (2) @(posedge clk);
                #1;
                rsp_v = 1'b1;
                rsp_d = rd;
                @(posedge clk); #1;
                rsp_v = 1'b0;
                rsp_d = '0;
            end
        end
    end

    // Monitor: every grant and every response must match the front of its expectation queue
    initial begin : monitor
        gnt_t e;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (if_gnt || dm_gnt) begin
                    if (exp_gnt.size() == 0) begin
                        chk("unexpected_gnt", 64'({if_gnt, dm_gnt}), 64'd0);
                    end else begin
                        e = exp_gnt.pop_front();
                        chk("gnt_who", 64'({if_gnt, dm_gnt}), e.is_dm ? 64'd1 : 64'd2);
                        chk("gnt_addr", 64'(mem_addr), 64'(e.addr));
                        chk("gnt_ctl", 64'({mem_we, mem_be, mem_wdata}), 64'({e.we, e.be, e.wdata}));
                    end
                end
                if (if_rvalid || dm_rvalid) begin
                    if (exp_rsp.size() == 0) begin
                        chk("unexpected_rvalid", 64'({if_rvalid, dm_rvalid}), 64'd0);
                    end else begin
                        r = exp_rsp.pop_front();
                        chk("rsp_who", 64'({if_rvalid, dm_rvalid}), r.is_dm ? 64'd1 : 64'd2);
                        chk("rsp_data", 64'(dm_rvalid ? dm_rdata : if_rdata), 64'(r.data));
                        chk("rsp_nonowner_rdata", 64'(dm_rvalid ? if_rdata : dm_rdata), 64'd0);
                    end
                end
            end
        end
    end

    // A requester must keep its request up while the arbiter holds it
    always @(negedge clk) begin
        if (rst_n && (dut.state_q == ARB_HOLD)) begin
            assert ((dut.owner_q == ARB_OWNER_IF) ? if_req : dm_req)
                else $error("requester dropped req while held");
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = 32'h0A00_0000 | 32'(i * 4);
            ref_mem[i] = 32'h0A00_0000 | 32'(i * 4);
        end
        mem_arr[64] = 32'h0000_0013;
        ref_mem[64] = 32'h0000_0013;

        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_addr = '0; dm_we = 1'b0; dm_be = '0; dm_wdata = '0;
        mem_gnt = 1'b0; rsp_en = 1'b1; stale_v = 1'b0; stale_d = '0;

        // 1: reset and idle, including a stray mem_gnt with nobody requesting
        repeat (3) begin
            @(negedge clk);
            chk_quiet("in_reset");
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c == 5) begin
                @(posedge clk); #1;
                mem_gnt = 1'b1;
            end
            @(negedge clk);
            chk_quiet("idle");
        end

        // 2: single fetch with cycle-exact latency
        @(posedge clk); #1;
        exp_if(32'h100, 1'b1);
        if_q.push_back(32'h100);
        fork
            run_if();
            begin
                @(negedge clk);
                chk("t2_c0_if_gnt", 64'({if_gnt, dm_gnt, mem_req}), 64'b101);
                @(negedge clk);
                chk("t2_c1_rvalid", 64'({if_rvalid, dm_rvalid, mem_req}), 64'd0);
                @(negedge clk);
                chk("t2_c2_if_rvalid", 64'({if_rvalid, dm_rvalid}), 64'b10);
                chk("t2_c2_if_rdata", 64'(if_rdata), 64'h13);
                chk("t2_c2_dm_rdata", 64'(dm_rdata), 64'd0);
            end
        join
        repeat (3) @(posedge clk);
        #1;

        // 3: simultaneous requests, data wins then fetch
        exp_dm(32'h200, 1'b1, 4'hF, 32'hDEADBEEF);
        exp_if(32'h104, 1'b1);
        dm_q.push_back(dm_op(32'h200, 1'b1, 4'hF, 32'hDEADBEEF));
        if_q.push_back(32'h104);
        fork
            run_if();
            run_dm();
        join
        repeat (4) @(posedge clk);
        #1;

        // 4: sustained data traffic against pending fetches: DM x4, IF, DM, DM, IF
        exp_dm(32'h204, 1'b1, 4'h3, 32'h11223344);
        exp_dm(32'h204, 1'b0, 4'hF, 32'h0);
        exp_dm(32'h200, 1'b0, 4'hF, 32'h0);
        exp_dm(32'h208, 1'b1, 4'h1, 32'hCAFE00AB);
        exp_if(32'h108, 1'b1);
        exp_dm(32'h208, 1'b0, 4'hF, 32'h0);
        exp_dm(32'h100, 1'b0, 4'hF, 32'h0);
        exp_if(32'h10C, 1'b1);
        dm_q.push_back(dm_op(32'h204, 1'b1, 4'h3, 32'h11223344));
        dm_q.push_back(dm_op(32'h204, 1'b0, 4'hF, 32'h0));
        dm_q.push_back(dm_op(32'h200, 1'b0, 4'hF, 32'h0));
        dm_q.push_back(dm_op(32'h208, 1'b1, 4'h1, 32'hCAFE00AB));
        dm_q.push_back(dm_op(32'h208, 1'b0, 4'hF, 32'h0));
        dm_q.push_back(dm_op(32'h100, 1'b0, 4'hF, 32'h0));
        if_q.push_back(32'h108);
        if_q.push_back(32'h10C);
        fork
            run_if();
            run_dm();
        join
        repeat (4) @(posedge clk);
        #1;

        // 5: memory stalls a fetch for 3 cycles while a data request arrives
        mem_gnt = 1'b0;
        exp_if(32'h300, 1'b1);
        exp_dm(32'h304, 1'b0, 4'hF, 32'h0);
        if_q.push_back(32'h300);
        dm_q.push_back(dm_op(32'h304, 1'b0, 4'hF, 32'h0));
        fork
            run_if();
            begin
                @(posedge clk); #1;
                run_dm();
            end
            begin
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    chk("t5_hold_req", 64'({mem_req, if_gnt, dm_gnt}), 64'b100);
                    chk("t5_hold_addr", 64'(mem_addr), 64'h300);
                end
                @(posedge clk); #1;
                mem_gnt = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;

        // 6: reset while waiting for a response; the late response must be dropped
        rsp_en = 1'b0;
        exp_if(32'h110, 1'b0);
        if_q.push_back(32'h110);
        run_if();
        chk("t6_wait_state", 64'(dut.state_q), 64'(ARB_WAIT_RSP));
        rst_n = 1'b0;
        #2;
        chk("t6_async_state", 64'(dut.state_q), 64'(ARB_IDLE));
        chk("t6_async_owner", 64'(dut.owner_q), 64'(ARB_OWNER_NONE));
        @(posedge clk); #1;
        rst_n   = 1'b1;
        stale_v = 1'b1;
        stale_d = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("t6_stale_rvalid", 64'({if_rvalid, dm_rvalid}), 64'd0);
        chk("t6_stale_rdata", {if_rdata, dm_rdata}, 64'd0);
        chk("t6_stale_state", 64'(dut.state_q), 64'(ARB_IDLE));
        @(posedge clk); #1;
        stale_v = 1'b0;
        stale_d = '0;
        rsp_en  = 1'b1;
        exp_dm(32'h200, 1'b0, 4'hF, 32'h0);
        dm_q.push_back(dm_op(32'h200, 1'b0, 4'hF, 32'h0));
        run_dm();
        repeat (5) @(posedge clk);
        #1;

        chk("gnt_queue_drained", 64'(exp_gnt.size()), 64'd0);
        chk("rsp_queue_drained", 64'(exp_rsp.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
